// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Main controller of a multicycle datapath, sitting directly upstream of the
// ALU. Each instruction is stepped through IF/ID/EXE/MEM/WB states. The opcode
// held in IR is decoded into the ALUOp code, the operand selects and all write
// enables. The ALU zero flag resolves beq.
//
// Optional feature (macro CU_PERF_CNT_EN):
//   defined   -> instret counts retired instructions (posedges with PCWre=1)
//   undefined -> instret is tied to 0 and no counter flops exist
//
// Parameters
//   OPW      opcode width
//   STATE_W  width of the debug state output
//   CNT_W    retired-instruction counter width
//
// Ports
//   CLK        in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   opcode     in   IR[31:26], stable from ID onward
//   zero       in   ALU zero flag
//   PCWre      out  PC write enable
//   IRWre      out  IR write enable
//   RegWre     out  register-file write enable
//   mRD        out  data-memory read strobe
//   mWR        out  data-memory write strobe
//   ALUSrcB    out  0 = rt, 1 = extended immediate
//   ExtSel     out  0 = zero-extend, 1 = sign-extend
//   DBDataSrc  out  0 = ALU result, 1 = memory data
//   WrRegDSrc  out  0 = PC+4 (jal), 1 = DB bus
//   RegDst     out  00 = rt, 01 = rd, 10 = $31
//   PCSrc      out  00 = PC+4, 01 = branch, 10 = rs (jr), 11 = jump target
//   ALUOp      out  000 add, 001 sub, 010 slt, 101 or, 110 and
//   state      out  current state (debug)
//   instret    out  retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OPW     = 6,
    parameter int STATE_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OPW-1:0]     opcode,
    input  logic               zero,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               mRD,
    output logic               mWR,
    output logic               ALUSrcB,
    output logic               ExtSel,
    output logic               DBDataSrc,
    output logic               WrRegDSrc,
    output logic [1:0]         RegDst,
    output logic [1:0]         PCSrc,
    output logic [2:0]         ALUOp,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instret
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_B  = 3'b101,
        S_EXE_A  = 3'b110,
        S_WB_A   = 3'b111
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_JR   = OPW'(6'b111001);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b111010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

    state_t state_reg;
    state_t state_next;

    logic is_rtype;
    logic is_arith;
    logic is_ls;
    logic is_jump;
    logic is_known;
    logic ends_in_id;
    logic [2:0] alu_code;

    assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR)
                   || (opcode == OP_AND) || (opcode == OP_SLT);
    assign is_arith = is_rtype || (opcode == OP_ADDI) || (opcode == OP_ORI);
    assign is_ls    = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_jump  = (opcode == OP_J) || (opcode == OP_JR) || (opcode == OP_JAL);
    assign is_known = is_arith || is_ls || is_jump
                   || (opcode == OP_BEQ) || (opcode == OP_HALT);
    // Jumps and unrecognised opcodes both retire in ID; unknowns act as a NOP.
    assign ends_in_id = is_jump || !is_known;

    always_comb begin
        alu_code = 3'b000;
        if ((opcode == OP_SUB) || (opcode == OP_BEQ))      alu_code = 3'b001;
        else if (opcode == OP_SLT)                         alu_code = 3'b010;
        else if ((opcode == OP_OR) || (opcode == OP_ORI))  alu_code = 3'b101;
        else if (opcode == OP_AND)                         alu_code = 3'b110;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_reg <= S_IF;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = S_IF;
        case (state_reg)
            S_IF:     state_next = S_ID;
            S_ID: begin
                if (is_arith)                 state_next = S_EXE_A;
                else if (opcode == OP_BEQ)    state_next = S_EXE_B;
                else if (is_ls)               state_next = S_EXE_LS;
                else if (opcode == OP_HALT)   state_next = S_ID;
                else                          state_next = S_IF;
            end
            S_EXE_A:  state_next = S_WB_A;
            S_WB_A:   state_next = S_IF;
            S_EXE_B:  state_next = S_IF;
            S_EXE_LS: state_next = S_MEM;
            S_MEM:    state_next = (opcode == OP_LW) ? S_WB_L : S_IF;
            S_WB_L:   state_next = S_IF;
            default:  state_next = S_IF;
        endcase
    end

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = 2'b00;
        PCSrc     = 2'b00;
        ALUOp     = 3'b000;
        // Reset is sampled combinationally so nothing strobes while it is held,
        // even though the state register already reads IF.
        if (!Reset) begin
            if (state_reg != S_IF) begin
                ALUSrcB   = is_ls || (opcode == OP_ADDI) || (opcode == OP_ORI);
                ExtSel    = (opcode != OP_ORI);
                DBDataSrc = (opcode == OP_LW);
                WrRegDSrc = (opcode != OP_JAL);
                RegDst    = is_rtype ? 2'b01 : ((opcode == OP_JAL) ? 2'b10 : 2'b00);
                ALUOp     = alu_code;
            end
            case (state_reg)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    PCWre  = ends_in_id;
                    RegWre = (opcode == OP_JAL);
                    if (opcode == OP_JR)                              PCSrc = 2'b10;
                    else if ((opcode == OP_J) || (opcode == OP_JAL))  PCSrc = 2'b11;
                end
                S_EXE_B: begin
                    PCWre = 1'b1;
                    PCSrc = {1'b0, zero};
                end
                S_MEM: begin
                    mRD   = (opcode == OP_LW);
                    mWR   = (opcode == OP_SW);
                    PCWre = (opcode == OP_SW);
                end
                S_WB_A, S_WB_L: begin
                    RegWre = 1'b1;
                    PCWre  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = STATE_W'(state_reg);

`ifdef CU_PERF_CNT_EN
    logic [CNT_W-1:0] instret_reg;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)      instret_reg <= '0;
        else if (PCWre) instret_reg <= instret_reg + 1'b1;
    end

    assign instret = instret_reg;
`else
    assign instret = '0;
`endif

endmodule
